// File: rtl/n_bit_serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// n_bit_serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encoding and
//   the width helper for the bit counter.
// ---------------------------------------------------------------------------
package n_bit_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width needed to count bit positions 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/n_bit_serial_subtractor_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//   Combinational 1-bit full subtractor cell: computes A - B - BIN.
//   Ports:
//     A, B  : minuend / subtrahend bits
//     BIN   : incoming borrow
//     DIFF  : difference bit
//     BOUT  : outgoing borrow
// ---------------------------------------------------------------------------
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BIN,
  output logic DIFF,
  output logic BOUT
);

  assign DIFF = A ^ B ^ BIN;
  // Borrow when B exceeds A outright, or A == B and a borrow is pending.
  assign BOUT = (~A & B) | (~(A ^ B) & BIN);

endmodule

// File: rtl/n_bit_serial_subtractor.sv
// ---------------------------------------------------------------------------
// n_bit_serial_subtractor
//   Bit-serial N-bit subtractor: OUT = A - B (mod 2^N), one bit per clock,
//   LSB first, with a registered borrow.
//   Ports:
//     CLK, RST              : clock, synchronous active-high reset
//     IN_VALID / IN_READY   : operand handshake (A, B sampled on accept)
//     A, B                  : minuend, subtrahend
//     OUT                   : difference
//     BORROW_OUT            : final borrow (A < B unsigned)
//     OVERFLOW              : signed overflow of A - B
//     OUT_VALID / OUT_READY : result handshake
//   Accept edge t0 -> OUT_VALID after edge t0+N. A new operation is only
//   accepted once the FSM is back in IDLE, giving an interval of N+2 cycles.
// ---------------------------------------------------------------------------
module n_bit_serial_subtractor
  import n_bit_serial_subtractor_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] OUT,
  output logic         BORROW_OUT,
  output logic         OVERFLOW,
  output logic         OUT_VALID,
  input  logic         OUT_READY
);

  localparam int CNT_W = cnt_w(N);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               borrow_q;
  logic [N-1:0]       opa_q;
  logic [N-1:0]       opb_q;
  logic [N-2:0]       res_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [N-1:0]       out_q;
  logic               borrow_out_q;
  logic               overflow_q;
  logic               out_valid_q;

  logic               diff_d;
  logic               bout_d;
  logic [N-1:0]       res_d;
  logic               accept;
  logic               last_bit;

  full_subtractor u_fs (
    .A    (opa_q[0]),
    .B    (opb_q[0]),
    .BIN  (borrow_q),
    .DIFF (diff_d),
    .BOUT (bout_d)
  );

  // Result so far with the current bit placed at the MSB; on the last bit
  // this is the complete difference.
  assign res_d    = {diff_d, res_q};
  assign last_bit = (cnt_q == CNT_W'(N - 1));

  // Ready is held low while reset is asserted so no accept can race it.
  assign IN_READY = (state_q == IDLE) && !RST;
  assign accept   = IN_VALID && IN_READY;

  assign OUT        = out_q;
  assign BORROW_OUT = borrow_out_q;
  assign OVERFLOW   = overflow_q;
  assign OUT_VALID  = out_valid_q;

  // Control FSM and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      out_q        <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          borrow_q <= bout_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_bit) begin
            out_q        <= res_d;
            borrow_out_q <= bout_d;
            // Overflow only possible when signs differ; then the result
            // sign must match the minuend sign.
            overflow_q   <= (sign_a_q != sign_b_q) && (diff_d != sign_a_q);
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand and partial-result shift registers; contents are don't-care
  // outside BUSY, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      opa_q    <= A;
      opb_q    <= B;
      sign_a_q <= A[N-1];
      sign_b_q <= B[N-1];
    end else if (state_q == BUSY) begin
      opa_q <= {1'b0, opa_q[N-1:1]};
      opb_q <= {1'b0, opb_q[N-1:1]};
      res_q <= res_d[N-1:1];
    end
  end

endmodule
